spi_inst_master: RTL and testbench
==================================

# spi_inst_master

SPI master that serialises 7-bit calculator instructions (3-bit opcode, 4-bit operand) into one 8-bit SPI frame each. It sits directly upstream of the SPI instruction slave/calculator. It drives that slave's `sclk`, `ss` and `mosi` inputs from the same `clk` domain, with one frame per accepted request. A valid/ready request port lets a host sequence load-A, load-B, add and subtract operations.

## Interface
- `CLK_DIV`, 4: half-period of `sclk` in `clk` cycles; legal ≥ 2.
- `GAP`, 8: `clk` cycles `ss` stays high after a frame before the next is accepted; legal ≥ 4.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  host has an instruction.
- `req_op`  in  3  opcode: 100 load A, 110 load B, 000 add (saturating), 001 sub; others sent unchanged.
- `req_data`  in  4  operand nibble.
- `req_ready`  out  1  high only in IDLE; transfer on `req_valid && req_ready`.
- `sclk`  out  1  SPI clock; idle low.
- `ss`  out  1  slave select; active low.
- `mosi`  out  1  serial data; idle high.
- `frame_done`  out  1  one-cycle pulse when `ss` returns high.

## Operation
- Frame word: {1'b0, op[2:0], data[3:0]}. Sent MSB first. Bit 7 is the zero/start bit.
- The slave samples `mosi` on `sclk` falling edges. The master therefore changes `mosi` only together with `sclk` rising, or in SETUP. It never changes `mosi` on a falling edge.
- On acceptance, `req_op`/`req_data` are latched into an 8-bit shift register. Later input changes have no effect on the frame.
- States:
  - IDLE: `ss`=1, `sclk`=0, `mosi`=1, `req_ready`=1. On accept, go to SETUP.
  - SETUP: `ss`=0, `sclk`=0, `mosi`=bit7 (0), for `CLK_DIV` cycles. Then go to HIGH.
  - HIGH: `sclk`=1 for `CLK_DIV` cycles. On every entry except the first, shift the register left and present the next bit. Then go to LOW.
  - LOW: `sclk`=0 for `CLK_DIV` cycles. A 3-bit bit counter increments on each HIGH→LOW transition. After the 8th falling edge, go to HOLD; otherwise go back to HIGH.
  - HOLD: `ss`=0, `sclk`=0, `mosi` holds bit0, for `CLK_DIV` cycles. Then go to GAP.
  - GAP: `ss`=1, `sclk`=0, `mosi`=1, for `GAP` cycles. `frame_done`=1 on the first GAP cycle only. Then go to IDLE.
- One shared phase counter (width clog2(max(CLK_DIV,GAP))) times all states. It reloads on every state change.
- All of `sclk`, `ss`, `mosi` and `frame_done` are registered outputs, with no combinational path from inputs. `req_ready` is decoded from state.
- Reset values: `sclk`=0, `ss`=1, `mosi`=1, `frame_done`=0. State is IDLE, so `req_ready`=1 while `rst` is high.
- Reset mid-frame: from the cycle after `rst` is sampled high, outputs return to idle levels. The partial frame is abandoned and no `frame_done` pulse is issued. The downstream slave is reset by the same `rst`.
- `req_valid` outside IDLE is ignored; the request is held by the host until `req_ready` is high.
- No opcode checking is done; undefined opcodes are transmitted verbatim.

## Timing
- Accept at edge t0. SETUP starts at cycle t0+1.
- `ss` is low for exactly 18·`CLK_DIV` cycles: t0+1 .. t0+18·`CLK_DIV`.
- Rising edge k (k=0..7) occurs at cycle t0+1+`CLK_DIV`·(1+2k). Falling edge k occurs `CLK_DIV` cycles later.
- `ss` goes high and `frame_done` pulses at cycle t0+1+18·`CLK_DIV`.
- `req_ready` goes high at cycle t0+1+18·`CLK_DIV`+`GAP`. With defaults: `frame_done` at t0+73, `req_ready` at t0+81.
- Back-to-back: with `req_valid` held high, the next accept occurs on the first IDLE cycle. Minimum frame period is 18·`CLK_DIV`+`GAP`+1 cycles.
- `GAP` ≥ 4 gives the slave's 2-cycle result pipeline time to finish before the next frame starts.

## Test plan
- Reset: hold `rst` for 3 cycles with `req_valid`=1 → `ss`=1, `sclk`=0, `mosi`=1, `frame_done`=0, `req_ready`=1. No frame starts until after `rst` falls.
- Single frame, defaults, op=100, data=0101 → `mosi` at the 8 falling edges is 0,1,0,0,0,1,0,1. `ss` is low for 72 cycles, `frame_done` at t0+73, `req_ready` at t0+81.
- Three back-to-back requests into the slave: load A=3, load B=2, add → exactly 3 frames, each separated by 8+1 cycles. Slave result = 5. Repeat with sub; result follows the slave's sub rule.
- Input stability: change `req_op`/`req_data` every cycle during a frame (op=110, data=1111 latched) → transmitted bits stay 0,1,1,0,1,1,1,1. The new request is accepted only when `req_ready`=1.
- Reset during the 5th HIGH phase → the next cycle shows `ss`=1, `sclk`=0, `mosi`=1 and no `frame_done`. A fresh request then produces a complete, correct frame.
- `CLK_DIV`=2, `GAP`=4: op=001, data=1000 → `ss` is low for 36 cycles, `sclk` period is 4 cycles, `mosi` never toggles in a falling-edge cycle, and `req_ready` returns at t0+41.

Source files
------------

// File: rtl/spi_inst_master.sv
// SPI master that sends one 8-bit calculator instruction frame {0, op, data} per accepted request.
// Frames go MSB first. mosi only changes alongside an sclk rise, so the slave can sample it on sclk falling edges.
module spi_inst_master #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  input  logic [3:0] req_data,
  output logic       req_ready,
  output logic       sclk,
  output logic       ss,
  output logic       mosi,
  output logic       frame_done
);

  localparam int PH_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam logic [PH_W-1:0] DIV_LOAD = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] GAP_LOAD = PH_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase;
  logic [2:0]      bit_cnt;
  // Only op/data are stored; the leading start bit is always zero and is driven directly in SETUP.
  logic [6:0]      shreg;
  logic            phase_end;
  logic            accept;

  assign req_ready = (state == S_IDLE);
  assign phase_end = (phase == '0);
  assign accept    = req_ready && req_valid;

  // Control: state, phase timer and registered SPI pins
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= '0;
      sclk       <= 1'b0;
      ss         <= 1'b1;
      mosi       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!phase_end) phase <= phase - PH_W'(1);
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state <= S_SETUP;
            phase <= DIV_LOAD;
            ss    <= 1'b0;
            mosi  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            state <= S_HIGH;
            phase <= DIV_LOAD;
            sclk  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            state <= S_LOW;
            phase <= DIV_LOAD;
            sclk  <= 1'b0;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            phase <= DIV_LOAD;
            // bit_cnt wraps to zero after the eighth falling edge
            if (bit_cnt == 3'd0) begin
              state <= S_HOLD;
            end else begin
              state <= S_HIGH;
              sclk  <= 1'b1;
              mosi  <= shreg[6];
            end
          end
        end
        S_HOLD: begin
          if (phase_end) begin
            state      <= S_GAP;
            phase      <= GAP_LOAD;
            ss         <= 1'b1;
            mosi       <= 1'b1;
            frame_done <= 1'b1;
          end
        end
        S_GAP: begin
          if (phase_end) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data: frame shift register and bit counter, loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= {req_op, req_data};
      bit_cnt <= 3'd0;
    end else begin
      if (state == S_HIGH && phase_end) bit_cnt <= bit_cnt + 3'd1;
      if (state == S_LOW && phase_end && bit_cnt != 3'd0) shreg <= {shreg[5:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_inst_master.sv
// Directed bench for spi_inst_master: default timing instance plus a CLK_DIV=2/GAP=4 instance.
module tb_spi_inst_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] valid = 2'b00;
  logic [1:0] ready, sclk, ss, mosi, fd;
  logic [2:0] op   [2];
  logic [3:0] data [2];

  spi_inst_master #(.CLK_DIV(4), .GAP(8)) dut0 (
    .clk(clk), .rst(rst), .req_valid(valid[0]), .req_op(op[0]), .req_data(data[0]),
    .req_ready(ready[0]), .sclk(sclk[0]), .ss(ss[0]), .mosi(mosi[0]), .frame_done(fd[0])
  );

  spi_inst_master #(.CLK_DIV(2), .GAP(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(valid[1]), .req_op(op[1]), .req_data(data[1]),
    .req_ready(ready[1]), .sclk(sclk[1]), .ss(ss[1]), .mosi(mosi[1]), .frame_done(fd[1])
  );

  // Pin monitor: captures mosi at each sclk fall and keeps running counters per instance
  int         ncyc = 0;
  int         nfall   [2] = '{0, 0};
  int         fe_viol [2] = '{0, 0};
  int         sslow   [2] = '{0, 0};
  int         nfd     [2] = '{0, 0};
  int         fd_cyc  [2] = '{0, 0};
  logic [7:0] cap     [2] = '{8'h00, 8'h00};
  logic [1:0] prev_sclk = 2'b00;
  logic [1:0] prev_mosi = 2'b11;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    for (int i = 0; i < 2; i++) begin
      prev_sclk[i] <= sclk[i];
      prev_mosi[i] <= mosi[i];
      if (!rst && prev_sclk[i] && !sclk[i]) begin
        nfall[i] <= nfall[i] + 1;
        cap[i]   <= {cap[i][6:0], mosi[i]};
        if (mosi[i] != prev_mosi[i]) fe_viol[i] <= fe_viol[i] + 1;
      end
      if (ss[i] == 1'b0) sslow[i] <= sslow[i] + 1;
      if (fd[i] == 1'b1) begin
        nfd[i]    <= nfd[i] + 1;
        fd_cyc[i] <= ncyc + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_t0  = -1000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Sends one request on instance i and checks bits, ss width, frame_done and req_ready timing.
  task automatic do_frame(input int i, input logic [2:0] o, input logic [3:0] d,
                          input bit scramble, input bit last, input bit b2b, input string tag);
    int         cd, gp, t0, f0, s0, v0, d0, n, rdy_t;
    logic [7:0] exp_w;
    cd    = (i == 0) ? 4 : 2;
    gp    = (i == 0) ? 8 : 4;
    exp_w = {1'b0, o, d};
    op[i]    = o;
    data[i]  = d;
    valid[i] = 1'b1;
    n = 0;
    while (!ready[i] && n < 300) begin
      tick();
      n++;
    end
    check_val({tag, "_accept"}, ready[i], 1);
    t0 = ncyc;
    if (b2b) check_val({tag, "_period"}, t0 - last_t0, 18 * cd + gp + 1);
    last_t0 = t0;
    f0 = nfall[i];
    s0 = sslow[i];
    v0 = fe_viol[i];
    d0 = nfd[i];
    n = 0;
    do begin
      tick();
      n++;
      if (scramble) begin
        op[i]   = 3'($urandom);
        data[i] = 4'($urandom);
      end
    end while (nfd[i] == d0 && n < 300);
    check_val({tag, "_done_time"}, fd_cyc[i] - t0, 18 * cd + 1);
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (ready[i]) break;
      if (scramble) begin
        op[i]   = 3'($urandom);
        data[i] = 4'($urandom);
      end
    end
    rdy_t = ncyc;
    if (last) valid[i] = 1'b0;
    check_val({tag, "_ready_time"}, rdy_t - t0, 18 * cd + gp + 1);
    check_val({tag, "_ss_low"}, sslow[i] - s0, 18 * cd);
    check_val({tag, "_falls"}, nfall[i] - f0, 8);
    check_val({tag, "_fall_toggle"}, fe_viol[i] - v0, 0);
    check_val({tag, "_word"}, cap[i], exp_w);
    check_val({tag, "_done_cnt"}, nfd[i] - d0, 1);
  endtask

  initial begin
    int t0, d0;
    op[0] = 3'b000; data[0] = 4'h0;
    op[1] = 3'b000; data[1] = 4'h0;

    // Reset held three cycles with requests pending
    valid = 2'b11;
    rst   = 1'b1;
    repeat (3) begin
      tick();
      check_val("rst_ss", ss, 2'b11);
    end
    check_val("rst_sclk", sclk, 2'b00);
    check_val("rst_mosi", mosi, 2'b11);
    check_val("rst_done", fd, 2'b00);
    check_val("rst_ready", ready, 2'b11);
    valid = 2'b00;
    rst   = 1'b0;
    tick();
    tick();
    check_val("post_rst_ss", ss, 2'b11);

    do_frame(0, 3'b100, 4'b0101, 1'b0, 1'b1, 1'b0, "single");

    do_frame(0, 3'b100, 4'b0011, 1'b0, 1'b0, 1'b0, "add_la");
    do_frame(0, 3'b110, 4'b0010, 1'b0, 1'b0, 1'b1, "add_lb");
    do_frame(0, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, "add_op");
    do_frame(0, 3'b100, 4'b0011, 1'b0, 1'b0, 1'b0, "sub_la");
    do_frame(0, 3'b110, 4'b0010, 1'b0, 1'b0, 1'b1, "sub_lb");
    do_frame(0, 3'b001, 4'b0000, 1'b0, 1'b1, 1'b1, "sub_op");

    do_frame(0, 3'b110, 4'b1111, 1'b1, 1'b1, 1'b0, "stable");

    // Abort a frame during the fifth sclk-high phase
    op[0]    = 3'b001;
    data[0]  = 4'b0110;
    valid[0] = 1'b1;
    check_val("abort_ready", ready[0], 1);
    t0 = ncyc;
    tick();
    valid[0] = 1'b0;
    while (ncyc < t0 + 38) tick();
    check_val("abort_in_high", sclk[0], 1);
    d0  = nfd[0];
    rst = 1'b1;
    tick();
    check_val("abort_ss", ss[0], 1);
    check_val("abort_sclk", sclk[0], 0);
    check_val("abort_mosi", mosi[0], 1);
    check_val("abort_done", fd[0], 0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check_val("abort_no_done", nfd[0] - d0, 0);
    check_val("abort_idle_ss", ss[0], 1);
    do_frame(0, 3'b001, 4'b0110, 1'b0, 1'b1, 1'b0, "after_abort");

    do_frame(1, 3'b001, 4'b1000, 1'b0, 1'b1, 1'b0, "div2");
    do_frame(0, 3'b111, 4'b1010, 1'b0, 1'b1, 1'b0, "undef_op");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
